// File: rtl/ad_pkg.sv
// rtl/ad_pkg.sv - shared types and constants for the ad_capture block
package ad_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/ad_capture_ram.sv
// rtl/ad_capture_ram.sv - simple dual-port sample buffer, one write port, one registered read port
module capture_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   // The array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ad_capture.sv
// rtl/ad_capture.sv - decimating edge-triggered capture into a circular frame buffer
// with a pre-trigger window and trigger-aligned readout.
module ad_capture
   import ad_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = 9,
   parameter int PRE_TRIG = 64,
   parameter int DECIM_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  ad_data,
   input  logic [DECIM_W-1:0] decim,
   input  logic               arm,
   input  logic               force_trig,
   input  logic               trig_slope,
   input  logic [DATA_W-1:0]  trig_level,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  trig_ptr
);

   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((2**ADDR_W) - PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    s_cur_q, s_prev_q;
   logic [DECIM_W-1:0]   dec_cnt_q, dec_cnt_d;
   logic [ADDR_W-1:0]    wptr_q, wptr_d;
   logic [ADDR_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [ADDR_W-1:0]    post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0]    trig_ptr_q, trig_ptr_d;
   logic                 rd_valid_q;

   logic                 strobe, arm_ok, wr_en, edge_hit, trig_fire;
   logic                 busy_w, done_w;
   logic [ADDR_W-1:0]    rd_phys;

   assign strobe = (dec_cnt_q == decim);
   assign arm_ok = arm & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   always_comb begin
      edge_hit = 1'b0;
      if (strobe) begin
         if (trig_slope == SLOPE_FALL) begin
            edge_hit = (s_prev_q > trig_level) && (s_cur_q <= trig_level);
         end else begin
            edge_hit = (s_prev_q < trig_level) && (s_cur_q >= trig_level);
         end
      end
   end

   assign trig_fire = (state_q == ST_WAIT_TRIG) & (edge_hit | force_trig);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (arm) state_d = ST_PRE;
         ST_PRE:       if (strobe && pre_cnt_q == PRE_LAST) state_d = ST_WAIT_TRIG;
         ST_WAIT_TRIG: if (trig_fire) state_d = ST_POST;
         ST_POST:      if (strobe && post_cnt_q == POST_LAST) state_d = ST_DONE;
         ST_DONE:      if (arm) state_d = ST_PRE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_w = 1'b0;
      done_w = 1'b0;
      case (state_q)
         ST_PRE, ST_WAIT_TRIG, ST_POST: busy_w = 1'b1;
         ST_DONE:                       done_w = 1'b1;
         default: ;
      endcase
   end

   assign wr_en = strobe & busy_w;

   // The trigger sample counts as the first post-trigger sample, whether it
   // was written on this strobe or (force without strobe) on the previous one.
   always_comb begin
      dec_cnt_d  = dec_cnt_q + 1'b1;
      wptr_d     = wptr_q;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      trig_ptr_d = trig_ptr_q;
      if (arm_ok) begin
         dec_cnt_d = '0;
         wptr_d    = '0;
         pre_cnt_d = '0;
      end else begin
         if (strobe) dec_cnt_d = '0;
         if (wr_en) wptr_d = wptr_q + 1'b1;
         if (state_q == ST_PRE && strobe) pre_cnt_d = pre_cnt_q + 1'b1;
         if (state_q == ST_POST && strobe) post_cnt_d = post_cnt_q + 1'b1;
         if (trig_fire) begin
            trig_ptr_d = strobe ? wptr_q : wptr_q - 1'b1;
            post_cnt_d = ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_cur_q    <= '0;
         s_prev_q   <= '0;
         dec_cnt_q  <= '0;
         wptr_q     <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         trig_ptr_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         s_cur_q    <= ad_data;
         if (strobe) s_prev_q <= s_cur_q;
         dec_cnt_q  <= dec_cnt_d;
         wptr_q     <= wptr_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         trig_ptr_q <= trig_ptr_d;
         rd_valid_q <= rd_en;
      end
   end

   assign rd_phys = trig_ptr_q - PRE_OFS + rd_addr;

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (s_cur_q),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_phys),
      .rd_data_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign busy     = busy_w;
   assign done     = done_w;
   assign trig_ptr = trig_ptr_q;

endmodule

// File: tb/tb_ad_capture.sv
// tb/tb_ad_capture.sv - scoreboard bench for ad_capture
module tb_ad_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  ad_data = '0;
   logic [15:0] decim = '0;
   logic        arm = 1'b0;
   logic        force_trig = 1'b0;
   logic        trig_slope = 1'b0;
   logic [7:0]  trig_level = 8'd100;
   logic        rd_en = 1'b0;
   logic [8:0]  rd_addr = '0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        busy;
   logic        done;
   logic [8:0]  trig_ptr;

   ad_capture dut (
      .clk        (clk),
      .rst        (rst),
      .ad_data    (ad_data),
      .decim      (decim),
      .arm        (arm),
      .force_trig (force_trig),
      .trig_slope (trig_slope),
      .trig_level (trig_level),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .done       (done),
      .trig_ptr   (trig_ptr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] ramp = '0;
   bit const_mode = 1'b0;
   bit ignore_rd = 1'b0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
      int         addr;
   } sb_t;
   sb_t sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      sb_t e;
      if (!ignore_rd && rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("rd[%0d]", e.addr), 32'(rd_data), 32'(e.data));
            check_eq("rd_lat", 32'(cyc - e.cyc), 32'd1);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      ad_data = const_mode ? 8'd50 : ramp;
      ramp = ramp + 8'd1;
   endtask

   function automatic int val(int a0, int dm, int j);
      return (a0 + dm + (dm + 1) * j) & 255;
   endfunction

   function automatic int find_trig(int a0, int dm, bit slope, int lvl);
      int cur, prev;
      for (int j = 64; j < 4000; j++) begin
         cur  = val(a0, dm, j);
         prev = val(a0, dm, j - 1);
         if (slope == 1'b0 ? (prev < lvl && cur >= lvl) : (prev > lvl && cur <= lvl))
            return j;
      end
      return -1;
   endfunction

   // Arms on the negedge that drives sample value 'target'; returns at offset 1.
   task automatic arm_at(input int target);
      for (int i = 0; i < 300; i++) begin
         tick();
         if (int'(ad_data) == target) break;
      end
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 4000; i++) begin
         if (done === 1'b1) break;
         tick();
      end
      check_eq(tag, 32'(done), 32'd1);
   endtask

   // cval >= 0 means every frame sample is that constant.
   task automatic read_frame(input int a0, input int dm, input int tj, input int cval);
      int ks[10] = '{0, 1, 2, 3, 63, 64, 65, 200, 510, 511};
      sb_t e;
      foreach (ks[i]) begin
         tick();
         rd_en   = 1'b1;
         rd_addr = 9'(ks[i]);
         e.data  = 8'(cval >= 0 ? cval : val(a0, dm, tj - 64 + ks[i]));
         e.cyc   = cyc;
         e.addr  = ks[i];
         sb_q.push_back(e);
      end
      tick();
      rd_en = 1'b0;
      tick();
      tick();
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic capture(input int target, input int dm, input bit slope, input int lvl, input string tag);
      int tj;
      decim      = 16'(dm);
      trig_slope = slope;
      trig_level = 8'(lvl);
      arm_at(target);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done({tag, "_done"});
      tj = find_trig(target, dm, slope, lvl);
      check_eq({tag, "_tptr"}, 32'(trig_ptr), 32'(tj % 512));
      read_frame(target, dm, tj, -1);
   endtask

   initial begin
      int off;
      #1 rst = 1'b1;
      #2;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_rdv", 32'(rd_valid), 32'd0);
      check_eq("rst_rdd", 32'(rd_data), 32'd0);
      check_eq("rst_tptr", 32'(trig_ptr), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      capture(0, 0, 1'b0, 100, "rise");
      capture(0, 0, 1'b1, 100, "fall");
      capture(0, 3, 1'b0, 100, "dec3");

      // arm in WAIT_TRIG and force in PRE must both be ignored
      decim = 16'd0;
      trig_slope = 1'b0;
      trig_level = 8'd100;
      arm_at(200);
      off = 1;
      while (off < 10) begin tick(); off++; end
      force_trig = 1'b1;
      tick(); off++;
      force_trig = 1'b0;
      while (off < 70) begin tick(); off++; end
      arm = 1'b1;
      tick(); off++;
      arm = 1'b0;
      check_eq("ign_busy", 32'(busy), 32'd1);
      wait_done("ign_done");
      check_eq("ign_tptr", 32'(trig_ptr), 32'd156);
      read_frame(200, 0, 156, -1);

      // constant input, forced trigger after 1000 clocks
      const_mode = 1'b1;
      tick();
      arm_at(50);
      off = 1;
      while (off < 1000) begin tick(); off++; end
      force_trig = 1'b1;
      tick(); off++;
      force_trig = 1'b0;
      while (off < 1447) begin tick(); off++; end
      check_eq("const_early", 32'(done), 32'd0);
      tick();
      check_eq("const_done", 32'(done), 32'd1);
      check_eq("const_tptr", 32'(trig_ptr), 32'd487);
      read_frame(0, 0, 0, 50);
      const_mode = 1'b0;

      // asynchronous reset in the middle of POST
      arm_at(0);
      off = 1;
      while (off < 200) begin tick(); off++; end
      ignore_rd = 1'b1;
      rd_en = 1'b1;
      tick();
      tick();
      check_eq("post_busy", 32'(busy), 32'd1);
      check_eq("post_rdv", 32'(rd_valid), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_done", 32'(done), 32'd0);
      check_eq("arst_rdv", 32'(rd_valid), 32'd0);
      rd_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
      ignore_rd = 1'b0;
      arm_at(0);
      check_eq("rearm_busy", 32'(busy), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
